// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ALU operand stage: opcodes, FSM encoding and
// instruction field layout {op, rd, rs1, rs2} (MSB-first).
package alu_operand_stage_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5,
    OP_SHR  = 3'd6,
    OP_SHL  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  localparam int OP_W    = 3;
  localparam int RS2_LSB = 0;

  function automatic int instr_w(input int ra_w);
    return OP_W + 3 * ra_w;
  endfunction

  function automatic int rs1_lsb(input int ra_w);
    return ra_w;
  endfunction

  function automatic int rd_lsb(input int ra_w);
    return 2 * ra_w;
  endfunction

  function automatic int op_lsb(input int ra_w);
    return 3 * ra_w;
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Instruction handshake and writeback report channel of the operand stage.
// master = upstream issuer / consumer of writeback reports, slave = the stage.
interface alu_operand_stage_if
  import alu_operand_stage_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RA_W   = 2
);
  logic                      instr_valid;
  logic                      instr_ready;
  logic [instr_w(RA_W)-1:0]  instr;
  logic                      wb_valid;
  logic [RA_W-1:0]           wb_addr;
  logic [DATA_W-1:0]         wb_data;

  modport master (
    output instr_valid, instr,
    input  instr_ready, wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, wb_valid, wb_addr, wb_data
  );
endinterface

// File: rtl/alu_regfile.sv
// Register file: two async read ports, two write ports (port A beats port B on
// an address collision). Define REG0_ZERO_EN to hard-wire R[0] to zero.
module alu_regfile #(
  parameter  int DATA_W = 8,
  parameter  int NREGS  = 4,
  localparam int RA_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RA_W-1:0]   ra1,
  input  logic [RA_W-1:0]   ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we_a,
  input  logic [RA_W-1:0]   wa_a,
  input  logic [DATA_W-1:0] wd_a,
  input  logic              we_b,
  input  logic [RA_W-1:0]   wa_b,
  input  logic [DATA_W-1:0] wd_b
);
`ifdef REG0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (!(R0_ZERO && i == 0)) begin
          if (we_a && wa_a == RA_W'(i))      regs[i] <= wd_a;
          else if (we_b && wa_b == RA_W'(i)) regs[i] <= wd_b;
        end
      end
    end
  end

  // Reads mask R[0] as well so the zero register never depends on reset state.
  assign rd1 = (R0_ZERO && ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (R0_ZERO && ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand fetch / writeback stage in front of an external ALU. Three-state
// FSM (IDLE -> EXEC -> WB): one instruction accepted every third cycle.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int NREGS  = 4,
  localparam int RA_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  alu_operand_stage_if.slave bus,
  input  logic              ld_en,
  input  logic [RA_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] operanda,
  output logic [DATA_W-1:0] operandb,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              zero_flag
);
  localparam int OP_LSB  = op_lsb(RA_W);
  localparam int RD_LSB  = rd_lsb(RA_W);
  localparam int RS1_LSB = rs1_lsb(RA_W);

  state_e            state;
  logic [RA_W-1:0]   rd_q;
  logic              wb_valid_q;
  logic [RA_W-1:0]   wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;

  logic [OP_W-1:0]   f_op;
  logic [RA_W-1:0]   f_rd, f_rs1, f_rs2;
  logic [DATA_W-1:0] rf_rd1, rf_rd2;

  assign f_op  = bus.instr[OP_LSB  +: OP_W];
  assign f_rd  = bus.instr[RD_LSB  +: RA_W];
  assign f_rs1 = bus.instr[RS1_LSB +: RA_W];
  assign f_rs2 = bus.instr[RS2_LSB +: RA_W];

  assign bus.instr_ready = (state == ST_IDLE);
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;

  // Operands come straight from the async read ports, so a same-edge load to
  // rs1/rs2 is not seen by the instruction being accepted.
  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk  (clk),
    .rst  (rst),
    .ra1  (f_rs1),
    .ra2  (f_rs2),
    .rd1  (rf_rd1),
    .rd2  (rf_rd2),
    .we_a (state == ST_EXEC),
    .wa_a (rd_q),
    .wd_a (alu_result),
    .we_b (ld_en),
    .wa_b (ld_addr),
    .wd_b (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      operanda   <= '0;
      operandb   <= '0;
      alu_op     <= '0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      zero_flag  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.instr_valid) begin
            alu_op   <= f_op;
            operanda <= rf_rd1;
            operandb <= rf_rd2;
            rd_q     <= f_rd;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // wb_data reports the ALU result even when R[0] drops the write.
          zero_flag  <= alu_zero;
          wb_valid_q <= 1'b1;
          wb_addr_q  <= rd_q;
          wb_data_q  <= alu_result;
          state      <= ST_WB;
        end
        ST_WB: begin
          wb_valid_q <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed scenarios plus random
// traffic against a register-array reference model. Honours REG0_ZERO_EN.
module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;

  localparam int DATA_W = 8;
  localparam int NREGS  = 4;
  localparam int RA_W   = 2;
  localparam int IW     = 3 + 3 * RA_W;
`ifdef REG0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_operand_stage_if #(.DATA_W(DATA_W), .RA_W(RA_W)) bus ();

  logic              ld_en;
  logic [RA_W-1:0]   ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] operanda, operandb, alu_result;
  logic [2:0]        alu_op;
  logic              alu_zero, zero_flag;

  alu_operand_stage #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .operanda   (operanda),
    .operandb   (operandb),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .zero_flag  (zero_flag)
  );

  function automatic logic [DATA_W-1:0] alu_fn(input logic [2:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return a + b;
      3'd5:    return a - b;
      3'd6:    return a >> b[2:0];
      default: return a << b[2:0];
    endcase
  endfunction

  // External ALU
  assign alu_result = alu_fn(alu_op, operanda, operandb);
  assign alu_zero   = (alu_result == '0);

  function automatic logic [IW-1:0] mk(input int op, input int rd, input int rs1, input int rs2);
    return {3'(op), RA_W'(rd), RA_W'(rs1), RA_W'(rs2)};
  endfunction

  typedef struct { int rd; int data; bit zero; } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  // Reference model: register array, phase counter (0 idle, 1 exec, 2 wb)
  int m_r [NREGS];
  int m_cnt = 0;
  bit m_acc = 1'b0;
  int p_op = 0, p_a = 0, p_b = 0, p_rd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_r[i] = 0;
    m_cnt = 0;
    m_acc = 1'b0;
    sb.delete();
  endtask

  task automatic model_edge();
    int old [NREGS];
    int res;
    if (rst) begin
      model_reset();
      return;
    end
    old   = m_r;
    m_acc = bus.instr_valid && (m_cnt == 0);
    if (ld_en && !(R0Z && ld_addr == 0)) m_r[ld_addr] = int'(ld_data);
    if (m_cnt == 1) begin
      res = int'(alu_fn(3'(p_op), DATA_W'(p_a), DATA_W'(p_b)));
      if (!(R0Z && p_rd == 0)) m_r[p_rd] = res;
      sb.push_back('{p_rd, res, res == 0});
    end
    if (m_acc) begin
      p_op = int'(bus.instr[8:6]);
      p_rd = int'(bus.instr[5:4]);
      p_a  = old[bus.instr[3:2]];
      p_b  = old[bus.instr[1:0]];
    end
    m_cnt = m_acc ? 1 : (m_cnt == 1 ? 2 : 0);
  endtask

  task automatic cyc(input bit le, input int la, input int ldd, input bit iv, input logic [IW-1:0] ins);
    @(negedge clk);
    ld_en           = le;
    ld_addr         = RA_W'(la);
    ld_data         = DATA_W'(ldd);
    bus.instr_valid = iv;
    bus.instr       = ins;
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 1'b0, '0);
  endtask

  task automatic chk_reset_state();
    chk("rst_operanda",  32'(operanda), 0);
    chk("rst_operandb",  32'(operandb), 0);
    chk("rst_alu_op",    32'(alu_op), 0);
    chk("rst_wb_valid",  32'(bus.wb_valid), 0);
    chk("rst_wb_addr",   32'(bus.wb_addr), 0);
    chk("rst_wb_data",   32'(bus.wb_data), 0);
    chk("rst_zero_flag", 32'(zero_flag), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    ld_en = 1'b0;
    bus.instr_valid = 1'b0;
    model_reset();
    #1 chk_reset_state();
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // Monitor: timing of ready/wb_valid, operand capture, writeback contents
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("instr_ready", 32'(bus.instr_ready), 32'(m_cnt == 0));
        chk("wb_valid",    32'(bus.wb_valid),    32'(m_cnt == 2));
        if (m_cnt == 1) begin
          chk("operanda", 32'(operanda), 32'(p_a));
          chk("operandb", 32'(operandb), 32'(p_b));
          chk("alu_op",   32'(alu_op),   32'(p_op));
        end
        if (bus.wb_valid === 1'b1) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wb_unexpected: got wb_addr=%0h wb_data=%0h with no pending instruction",
                     bus.wb_addr, bus.wb_data);
          end else begin
            e = sb.pop_front();
            chk("wb_addr",   32'(bus.wb_addr), 32'(e.rd));
            chk("wb_data",   32'(bus.wb_data), 32'(e.data));
            chk("zero_flag", 32'(zero_flag),   32'(e.zero));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [IW-1:0] cur;
    bit offer;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    bus.instr_valid = 1'b0; bus.instr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 chk_reset_state();
    @(negedge clk);
    #2 rst = 1'b0;

    // ADD R3 = 0x0F + 0x35
    cyc(1, 1, 'h0F, 0, '0);
    cyc(1, 2, 'h35, 0, '0);
    cyc(0, 0, 0, 1, mk(OP_ADD, 3, 1, 2));
    idle(3);

    // AND to zero, instr_valid held so acceptance spacing is exercised
    cyc(1, 1, 'hAA, 0, '0);
    cyc(1, 2, 'h55, 0, '0);
    repeat (7) cyc(0, 0, 0, 1, mk(OP_AND, 1, 1, 2));
    idle(3);

    // load collides with ALU writeback on R3; ALU value must survive
    cyc(1, 1, 'h0F, 0, '0);
    cyc(1, 2, 'h35, 0, '0);
    cyc(0, 0, 0, 1, mk(OP_ADD, 3, 1, 2));
    cyc(1, 3, 'h77, 0, '0);
    idle(2);
    cyc(0, 0, 0, 1, mk(OP_OR, 0, 3, 3));
    idle(3);
    // load to another register on the writeback edge
    cyc(0, 0, 0, 1, mk(OP_ADD, 3, 1, 1));
    cyc(1, 2, 'h99, 0, '0);
    idle(2);
    cyc(0, 0, 0, 1, mk(OP_XOR, 0, 2, 3));
    idle(3);

    // load to a source register on the acceptance edge
    cyc(1, 1, 'h3C, 1, mk(OP_SUB, 2, 1, 3));
    idle(3);

    // reset while SUB is in EXEC
    cyc(1, 1, 'h05, 0, '0);
    cyc(1, 3, 'h02, 0, '0);
    cyc(0, 0, 0, 1, mk(OP_SUB, 2, 1, 3));
    pulse_reset();
    idle(2);
    cyc(0, 0, 0, 1, mk(OP_OR, 3, 2, 2));
    idle(3);

    // R0 behaviour
    cyc(1, 0, 'hFF, 0, '0);
    cyc(0, 0, 0, 1, mk(OP_OR, 1, 0, 0));
    idle(3);
    cyc(0, 0, 0, 1, mk(OP_XOR, 2, 1, 1));
    idle(3);

    // random traffic; an offered instruction is held until accepted
    offer = 1'b0;
    cur   = '0;
    for (int n = 0; n < 500; n++) begin
      if (!offer) begin
        offer = ($urandom_range(0, 9) < 6);
        cur   = IW'($urandom);
      end
      cyc($urandom_range(0, 3) == 0, int'($urandom_range(0, NREGS - 1)),
          int'($urandom_range(0, 255)), offer, cur);
      if (m_acc) offer = 1'b0;
    end
    idle(4);

    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
